// File: rtl/port_sel_bank_if.sv
// port_sel_bank_if: strobed register bus between a bus master and the select-register bank
interface port_sel_bank_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W = 2
);
  logic [DATA_W-1:0] data_o;
  logic [IDX_W+1:0]  addr;
  logic              wr_n;
  logic              rd_n;
  logic              en;
  logic [DATA_W-1:0] data_i;
  modport master (output data_o, addr, wr_n, rd_n, en, input data_i);
  modport slave (input data_o, addr, wr_n, rd_n, en, output data_i);
endinterface

// File: rtl/port_sel_bank.sv
// port_sel_bank: bank of pin/peripheral select registers written over an asynchronously strobed bus
module port_sel_bank #(
  parameter int DATA_W = 8,
  parameter int NUM_REGS = 4,
  parameter int IDX_W = 2,
  parameter int PULSE_CYC = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  port_sel_bank_if.slave             bus,
  output logic [NUM_REGS*DATA_W-1:0] sel,
  output logic [NUM_REGS-1:0]        pulse_busy
);
  localparam int CW = $clog2(PULSE_CYC + 1);
  logic [DATA_W-1:0] reg_q [NUM_REGS];
  logic [DATA_W-1:0] reg_d [NUM_REGS];
  logic [DATA_W-1:0] pend_q [NUM_REGS];
  logic [DATA_W-1:0] pend_d [NUM_REGS];
  logic [CW-1:0]     cnt_q [NUM_REGS];
  logic [CW-1:0]     cnt_d [NUM_REGS];
  logic [2:0]        sync_q;
  logic              cap_en_q;
  logic [IDX_W+1:0]  cap_addr_q;
  logic [DATA_W-1:0] cap_data_q;
  logic [DATA_W-1:0] data_i_q;
  logic [DATA_W-1:0] rd_d;
  logic              commit;
  logic [1:0]        op;
  logic [IDX_W-1:0]  idx;
  // commit fires once, two clocks after the strobe's rising edge is first seen
  assign commit = sync_q[1] & ~sync_q[2] & cap_en_q;
  assign op = cap_addr_q[IDX_W+1:IDX_W];
  assign idx = cap_addr_q[IDX_W-1:0];
  assign bus.data_i = data_i_q;
  // expiry is resolved first so a same-cycle op acts on the post-expiry value
  always_comb begin
    rd_d = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      reg_d[k] = (cnt_q[k] == CW'(1)) ? reg_q[k] & ~pend_q[k] : reg_q[k];
      pend_d[k] = (cnt_q[k] == CW'(1)) ? '0 : pend_q[k];
      cnt_d[k] = (cnt_q[k] != '0) ? cnt_q[k] - CW'(1) : '0;
      if (commit && idx == IDX_W'(k))
        case (op)
          2'b00: begin
            reg_d[k] = cap_data_q;
            pend_d[k] = '0;
            cnt_d[k] = '0;
          end
          2'b01: reg_d[k] = reg_d[k] | cap_data_q;
          2'b10: begin
            reg_d[k] = reg_d[k] & ~cap_data_q;
            pend_d[k] = pend_d[k] & ~cap_data_q;
          end
          2'b11: begin
            reg_d[k] = reg_d[k] | cap_data_q;
            pend_d[k] = pend_d[k] | cap_data_q;
            cnt_d[k] = CW'(PULSE_CYC);
          end
        endcase
      if (bus.addr[IDX_W-1:0] == IDX_W'(k)) rd_d = reg_q[k];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 3'b111;
      cap_en_q <= 1'b0;
      cap_addr_q <= '0;
      cap_data_q <= '0;
      data_i_q <= '0;
      reg_q <= '{default: RESET_VAL};
      pend_q <= '{default: '0};
      cnt_q <= '{default: '0};
    end else begin
      sync_q <= {sync_q[1:0], bus.wr_n};
      if (!bus.wr_n) {cap_en_q, cap_addr_q, cap_data_q} <= {bus.en, bus.addr, bus.data_o};
      if (bus.en && !bus.rd_n) data_i_q <= rd_d;
      reg_q <= reg_d;
      pend_q <= pend_d;
      cnt_q <= cnt_d;
    end
  end
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign sel[g*DATA_W +: DATA_W] = reg_q[g];
    assign pulse_busy[g] = cnt_q[g] != '0;
  end
endmodule

// File: tb/tb_port_sel_bank.sv
// tb_port_sel_bank: randomized and directed bus traffic checked every clock against a timeline model
module tb_port_sel_bank;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int IW = 3;
  localparam int PC = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  port_sel_bank_if #(.DATA_W(DW), .IDX_W(IW)) bus ();
  logic [NR*DW-1:0] sel;
  logic [NR-1:0]    pulse_busy;
  port_sel_bank #(.DATA_W(DW), .NUM_REGS(NR), .IDX_W(IW), .PULSE_CYC(PC), .RESET_VAL('0)) dut (
    .clk(clk), .rst(rst), .bus(bus), .sel(sel), .pulse_busy(pulse_busy)
  );
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] m_reg [NR];
  logic [DW-1:0] m_pend [NR];
  int            m_exp [NR];
  logic [DW-1:0] m_rd;
  int            e = 0;
  int            commit_at = 0;
  logic          prev_low = 1'b0;
  logic          c_en, s_en;
  logic [1:0]    c_op, s_op;
  int            c_idx, s_idx;
  logic [DW-1:0] c_data, s_data;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
    end
  endtask
  // model works on absolute edge numbers: commits scheduled two edges after the rise, expiries at a fixed edge
  task automatic tick();
    logic [NR*DW-1:0] x_sel;
    logic [NR-1:0]    x_busy;
    int ri;
    @(posedge clk);
    e++;
    if (rst) begin
      for (int k = 0; k < NR; k++) begin
        m_reg[k] = '0;
        m_pend[k] = '0;
        m_exp[k] = 0;
      end
      m_rd = '0;
      commit_at = 0;
      prev_low = 1'b0;
      c_en = 1'b0;
    end else begin
      ri = int'(bus.addr[IW-1:0]);
      if (bus.en && !bus.rd_n) m_rd = (ri < NR) ? m_reg[ri] : '0;
      for (int k = 0; k < NR; k++)
        if (m_exp[k] == e) begin
          m_reg[k] &= ~m_pend[k];
          m_pend[k] = '0;
          m_exp[k] = 0;
        end
      if (e == commit_at && s_en && s_idx < NR)
        case (s_op)
          2'd0: begin m_reg[s_idx] = s_data; m_pend[s_idx] = '0; m_exp[s_idx] = 0; end
          2'd1: m_reg[s_idx] |= s_data;
          2'd2: begin m_reg[s_idx] &= ~s_data; m_pend[s_idx] &= ~s_data; end
          2'd3: begin m_reg[s_idx] |= s_data; m_pend[s_idx] |= s_data; m_exp[s_idx] = e + PC; end
        endcase
      if (!bus.wr_n) begin
        c_en = bus.en;
        c_op = bus.addr[IW+1:IW];
        c_idx = int'(bus.addr[IW-1:0]);
        c_data = bus.data_o;
      end else if (prev_low) begin
        commit_at = e + 2;
        s_en = c_en;
        s_op = c_op;
        s_idx = c_idx;
        s_data = c_data;
      end
      prev_low = !bus.wr_n;
    end
    #1;
    for (int k = 0; k < NR; k++) begin
      x_sel[k*DW +: DW] = m_reg[k];
      x_busy[k] = m_exp[k] != 0;
    end
    chk("sel", sel, x_sel);
    chk("pulse_busy", pulse_busy, x_busy);
    chk("data_i", bus.data_i, m_rd);
  endtask
  task automatic idle(input int n);
    repeat (n) tick();
  endtask
  task automatic wr(input logic [1:0] op, input int idx, input logic [DW-1:0] d, input logic en_v, input int low);
    bus.addr = {op, IW'(idx)};
    bus.data_o = d;
    bus.en = en_v;
    bus.wr_n = 1'b0;
    repeat (low) tick();
    bus.wr_n = 1'b1;
    bus.en = 1'b0;
  endtask
  task automatic wrc(input logic [1:0] op, input int idx, input logic [DW-1:0] d, input logic en_v);
    wr(op, idx, d, en_v, 2);
    idle(4);
  endtask
  task automatic rd(input int idx);
    bus.addr = {2'($urandom_range(0, 3)), IW'(idx)};
    bus.en = 1'b1;
    bus.rd_n = 1'b0;
    tick();
    bus.rd_n = 1'b1;
    bus.en = 1'b0;
  endtask
  initial begin
    bus.data_o = '0;
    bus.addr = '0;
    bus.wr_n = 1'b1;
    bus.rd_n = 1'b1;
    bus.en = 1'b0;
    idle(2);
    rst = 1'b0;
    tick();
    chk("rst_sel", sel, 0);
    chk("rst_data_i", bus.data_i, 0);
    chk("rst_busy", pulse_busy, 0);
    idle(10);
    chk("idle_sel", sel, 0);
    wr(2'd0, 1, 8'hA5, 1'b1, 3);
    idle(2);
    chk("lat_early", sel[15:8], 8'h00);
    idle(1);
    chk("lat_commit", sel[15:8], 8'hA5);
    chk("others_zero", {sel[31:16], sel[7:0]}, 0);
    wrc(2'd1, 1, 8'h0A, 1'b1);
    chk("set", sel[15:8], 8'hAF);
    wrc(2'd2, 1, 8'h21, 1'b1);
    chk("clear", sel[15:8], 8'h8E);
    wrc(2'd0, 1, 8'hFF, 1'b0);
    chk("en_low", sel[15:8], 8'h8E);
    wrc(2'd0, 5, 8'hFF, 1'b1);
    chk("idx_oob", sel, 32'h0000_8E00);
    rd(1);
    chk("read", bus.data_i, 8'h8E);
    idle(3);
    chk("read_hold", bus.data_i, 8'h8E);
    wr(2'd3, 0, 8'h03, 1'b1, 1);
    idle(3);
    chk("pulse_on", {pulse_busy[0], sel[1:0]}, 3'b111);
    idle(PC - 1);
    chk("pulse_last", {pulse_busy[0], sel[1:0]}, 3'b111);
    idle(1);
    chk("pulse_off", {pulse_busy[0], sel[1:0]}, 3'b000);
    wr(2'd3, 0, 8'h03, 1'b1, 1);
    idle(8);
    wr(2'd3, 0, 8'h04, 1'b1, 1);
    idle(3);
    chk("repulse_on", sel[2:0], 3'b111);
    idle(PC - 1);
    chk("repulse_last", sel[2:0], 3'b111);
    idle(1);
    chk("repulse_off", sel[2:0], 3'b000);
    wr(2'd3, 0, 8'h03, 1'b1, 1);
    idle(3);
    wr(2'd2, 0, 8'h01, 1'b1, 1);
    idle(3);
    chk("mid_clear", {pulse_busy[0], sel[1:0]}, 3'b110);
    idle(PC);
    chk("mid_clear_exp", {pulse_busy[0], sel[1:0]}, 3'b000);
    wr(2'd3, 0, 8'h03, 1'b1, 1);
    idle(3);
    wr(2'd0, 0, 8'hF0, 1'b1, 1);
    idle(3);
    chk("mid_write", {pulse_busy[0], sel[7:0]}, 9'h0F0);
    idle(PC + 2);
    chk("mid_write_hold", {pulse_busy[0], sel[7:0]}, 9'h0F0);
    bus.addr = {2'd0, IW'(2)};
    bus.data_o = 8'h55;
    bus.en = 1'b1;
    bus.wr_n = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    bus.wr_n = 1'b1;
    bus.en = 1'b0;
    idle(5);
    chk("rst_mid_write", sel, 0);
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 7) begin
        wr(2'($urandom_range(0, 3)), $urandom_range(0, 7), 8'($urandom), $urandom_range(0, 7) != 0,
           $urandom_range(1, 4));
        bus.data_o = 8'($urandom);
        idle($urandom_range(2, 6));
      end else if (r < 9) begin
        rd($urandom_range(0, 7));
      end else begin
        idle($urandom_range(5, 20));
      end
    end
    idle(PC + 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
